// File: rtl/dp_bidir_ram_arb.sv
// Dual-port RAM with bidirectional data buses, same-address write arbitration,
// write-through bypass to the opposite port and a post-reset memory clear sweep.
module dp_bidir_ram_arb #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 4,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs_0,
   input  logic              cs_1,
   input  logic              wr_en_0,
   input  logic              wr_en_1,
   input  logic              out_en_0,
   input  logic              out_en_1,
   input  logic [ADDR_W-1:0] add_in_0,
   input  logic [ADDR_W-1:0] add_in_1,
   inout  wire  [DATA_W-1:0] data_io_0,
   inout  wire  [DATA_W-1:0] data_io_1,
   output logic              rd_valid_0,
   output logic              rd_valid_1,
   output logic              collision,
   output logic              init_busy
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   logic [DATA_W-1:0]              mem [DEPTH];
   state_t                         state_reg;
   logic [ADDR_W-1:0]              ptr_reg;
   logic                           turn_reg;

   logic [1:0]                     cs;
   logic [1:0]                     wr;
   logic [1:0]                     oe;
   logic [1:0][ADDR_W-1:0]         addr;
   logic [1:0][DATA_W-1:0]         wdata;
   logic [1:0]                     wr_req;
   logic [1:0]                     rd_req;
   logic [1:0]                     we;
   logic                           run;
   logic                           clash;
   logic                           sweep_we;

   assign cs    = {cs_1, cs_0};
   assign wr    = {wr_en_1, wr_en_0};
   assign oe    = {out_en_1, out_en_0};
   assign addr  = {add_in_1, add_in_0};
   assign wdata = {data_io_1, data_io_0};

   always_comb begin
      run      = (state_reg == ST_RUN);
      sweep_we = (state_reg == ST_INIT);
      wr_req   = {2{run}} & cs & wr;
      rd_req   = {2{run}} & cs & ~wr;
      clash    = wr_req[0] & wr_req[1] & (addr[0] == addr[1]);
      // On a clash only the port named by turn_reg keeps its write enable
      we[0]    = wr_req[0] & ~(clash & turn_reg);
      we[1]    = wr_req[1] & ~(clash & ~turn_reg);
   end

   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem[ptr_reg] <= INIT_VAL;
      end
      if (we[0]) begin
         mem[addr[0]] <= wdata[0];
      end
      if (we[1]) begin
         mem[addr[1]] <= wdata[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_INIT;
         ptr_reg   <= '0;
         init_busy <= 1'b1;
         collision <= 1'b0;
         turn_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_INIT: begin
               collision <= 1'b0;
               // Pointer parks at the last word; leaving INIT is the only exit
               if (&ptr_reg) begin
                  state_reg <= ST_RUN;
                  init_busy <= 1'b0;
               end else begin
                  ptr_reg <= ptr_reg + 1'b1;
               end
            end
            ST_RUN: begin
               collision <= clash;
               if (clash) begin
                  turn_reg <= ~turn_reg;
               end
            end
            default: begin
               state_reg <= ST_INIT;
            end
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         localparam int OTHER = 1 - gi;
         logic [DATA_W-1:0] rd_data_reg;
         logic              rd_valid_reg;
         logic              bypass;

         assign bypass = we[OTHER] & (addr[OTHER] == addr[gi]);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_data_reg  <= '0;
               rd_valid_reg <= 1'b0;
            end else begin
               rd_valid_reg <= rd_req[gi];
               if (rd_req[gi]) begin
                  rd_data_reg <= bypass ? wdata[OTHER] : mem[addr[gi]];
               end
            end
         end
      end
   endgenerate

   assign rd_valid_0 = g_port[0].rd_valid_reg;
   assign rd_valid_1 = g_port[1].rd_valid_reg;

   assign data_io_0 = (g_port[0].rd_valid_reg && oe[0]) ? g_port[0].rd_data_reg : 'z;
   assign data_io_1 = (g_port[1].rd_valid_reg && oe[1]) ? g_port[1].rd_data_reg : 'z;

endmodule

// File: tb/tb_dp_bidir_ram_arb.sv
// Bench for dp_bidir_ram_arb: word-level memory model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_dp_bidir_ram_arb;

   localparam int          DW    = 8;
   localparam int          AW    = 4;
   localparam int          DEPTH = 16;
   localparam logic [7:0]  PROBE = 8'h3C;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs_0 = 1'b0, cs_1 = 1'b0;
   logic        wr_en_0 = 1'b0, wr_en_1 = 1'b0;
   logic        out_en_0 = 1'b0, out_en_1 = 1'b0;
   logic [3:0]  add_in_0 = '0, add_in_1 = '0;
   logic [7:0]  wd_0 = '0, wd_1 = '0;
   wire  [7:0]  data_io_0;
   wire  [7:0]  data_io_1;
   logic        rd_valid_0, rd_valid_1, collision, init_busy;

   int          n_checks = 0;
   int          n_err = 0;
   logic        chk_en = 1'b0;
   int          busy_cnt = 0;

   // Behavioural model state
   logic [7:0]  m_mem [DEPTH];
   int          busy_left = DEPTH;
   logic        ev0 = 1'b0, ev1 = 1'b0, ecoll = 1'b0, turn = 1'b0;
   logic [7:0]  erd0 = '0, erd1 = '0;

   always #5 clk = ~clk;

   dp_bidir_ram_arb #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(8'h00)) dut (
      .clk(clk), .rst_n(rst_n),
      .cs_0(cs_0), .cs_1(cs_1),
      .wr_en_0(wr_en_0), .wr_en_1(wr_en_1),
      .out_en_0(out_en_0), .out_en_1(out_en_1),
      .add_in_0(add_in_0), .add_in_1(add_in_1),
      .data_io_0(data_io_0), .data_io_1(data_io_1),
      .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
      .collision(collision), .init_busy(init_busy)
   );

   // The bench drives write data, or a probe pattern whenever the DUT must float
   wire         tb_drv_0 = !(ev0 && out_en_0);
   wire         tb_drv_1 = !(ev1 && out_en_1);
   wire [7:0]   tb_val_0 = (cs_0 && wr_en_0) ? wd_0 : PROBE;
   wire [7:0]   tb_val_1 = (cs_1 && wr_en_1) ? wd_1 : PROBE;
   assign data_io_0 = tb_drv_0 ? tb_val_0 : 'z;
   assign data_io_1 = tb_drv_1 ? tb_val_1 : 'z;

   // Value a word holds after one RUN cycle of write requests
   function automatic logic [7:0] word_after(input logic [7:0] old, input logic [3:0] at,
                                             input logic w0, input logic [3:0] ad0, input logic [7:0] d0,
                                             input logic w1, input logic [3:0] ad1, input logic [7:0] d1,
                                             input logic t);
      logic [7:0] r;
      r = old;
      if (w0 && w1 && ad0 == ad1) begin
         if (at == ad0) r = t ? d1 : d0;
      end else begin
         if (w0 && at == ad0) r = d0;
         if (w1 && at == ad1) r = d1;
      end
      return r;
   endfunction

   wire m_w0 = cs_0 && wr_en_0;
   wire m_w1 = cs_1 && wr_en_1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_left <= DEPTH;
         ev0 <= 1'b0; ev1 <= 1'b0; ecoll <= 1'b0; turn <= 1'b0;
         erd0 <= '0; erd1 <= '0;
      end else if (busy_left > 0) begin
         m_mem[DEPTH - busy_left] <= 8'h00;
         busy_left <= busy_left - 1;
         ev0 <= 1'b0; ev1 <= 1'b0; ecoll <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            m_mem[i] <= word_after(m_mem[i], 4'(i), m_w0, add_in_0, wd_0, m_w1, add_in_1, wd_1, turn);
         ev0 <= cs_0 && !wr_en_0;
         ev1 <= cs_1 && !wr_en_1;
         if (cs_0 && !wr_en_0)
            erd0 <= word_after(m_mem[add_in_0], add_in_0, m_w0, add_in_0, wd_0, m_w1, add_in_1, wd_1, turn);
         if (cs_1 && !wr_en_1)
            erd1 <= word_after(m_mem[add_in_1], add_in_1, m_w0, add_in_0, wd_0, m_w1, add_in_1, wd_1, turn);
         ecoll <= m_w0 && m_w1 && (add_in_0 == add_in_1);
         if (m_w0 && m_w1 && (add_in_0 == add_in_1)) turn <= !turn;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) busy_cnt <= 0;
      else if (init_busy) busy_cnt <= busy_cnt + 1;
      if (chk_en) begin
         check("init_busy", {31'b0, init_busy}, {31'b0, busy_left > 0});
         check("rd_valid_0", {31'b0, rd_valid_0}, {31'b0, ev0});
         check("rd_valid_1", {31'b0, rd_valid_1}, {31'b0, ev1});
         check("collision", {31'b0, collision}, {31'b0, ecoll});
         check("data_io_0", {24'b0, data_io_0}, {24'b0, (ev0 && out_en_0) ? erd0 : tb_val_0});
         check("data_io_1", {24'b0, data_io_1}, {24'b0, (ev1 && out_en_1) ? erd1 : tb_val_1});
      end
   end

   task automatic step(input logic c0, input logic w0, input logic o0, input logic [3:0] a0, input logic [7:0] d0,
                       input logic c1, input logic w1, input logic o1, input logic [3:0] a1, input logic [7:0] d1);
      cs_0 = c0; wr_en_0 = w0; out_en_0 = o0; add_in_0 = a0; wd_0 = d0;
      cs_1 = c1; wr_en_1 = w1; out_en_1 = o1; add_in_1 = a1; wd_1 = d1;
      $display("%0t p0 cs=%b we=%b oe=%b a=%h d=%h | p1 cs=%b we=%b oe=%b a=%h d=%h",
               $time, c0, w0, o0, a0, d0, c1, w1, o1, a1, d1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 8'h00);
   endtask

   task automatic collide(input logic [7:0] d0, input logic [7:0] d1);
      step(1, 1, 0, 4'h7, d0, 1, 1, 0, 4'h7, d1);
      check("coll_pulse", {31'b0, collision}, 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("rst_busy", {31'b0, init_busy}, 32'd1);
      check("rst_valid0", {31'b0, rd_valid_0}, 32'd0);
      check("rst_coll", {31'b0, collision}, 32'd0);

      // Release; requests during the sweep must be ignored
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++)
         step(1, 1, 0, 4'(i), 8'hF0 | 8'(i), 1, 0, 1, 4'(i), 8'h00);
      check("busy_cycles", busy_cnt, 32'd16);
      check("busy_done", {31'b0, init_busy}, 32'd0);

      for (int i = 0; i < DEPTH; i++) begin
         step(1, 0, 1, 4'(i), 8'h00, 0, 0, 0, 4'h0, 8'h00);
         check("clear_valid", {31'b0, rd_valid_0}, 32'd1);
         check("clear_data", {24'b0, data_io_0}, 32'h00);
      end
      idle();
      check("valid_once", {31'b0, rd_valid_0}, 32'd0);

      // Write on port 0, read back on port 1
      step(1, 1, 0, 4'h3, 8'hA5, 0, 0, 0, 4'h0, 8'h00);
      step(0, 0, 0, 4'h0, 8'h00, 1, 0, 1, 4'h3, 8'h00);
      check("xport_valid", {31'b0, rd_valid_1}, 32'd1);
      check("xport_data", {24'b0, data_io_1}, 32'hA5);
      step(0, 0, 0, 4'h0, 8'h00, 0, 0, 1, 4'h0, 8'h00);
      check("xport_valid_end", {31'b0, rd_valid_1}, 32'd0);
      check("xport_hiz", {24'b0, data_io_1}, {24'b0, PROBE});

      // Back-to-back collisions alternate the winner
      collide(8'h11, 8'h22);
      collide(8'h11, 8'h22);
      check("model_mem7", {24'b0, m_mem[7]}, 32'h22);
      step(1, 0, 1, 4'h7, 8'h00, 0, 0, 0, 4'h0, 8'h00);
      check("coll_clear", {31'b0, collision}, 32'd0);
      check("coll_data_a", {24'b0, data_io_0}, 32'h22);
      collide(8'h33, 8'h44);
      step(1, 0, 1, 4'h7, 8'h00, 0, 0, 0, 4'h0, 8'h00);
      check("coll_data_b", {24'b0, data_io_0}, 32'h33);
      collide(8'h55, 8'h66);
      step(1, 0, 1, 4'h7, 8'h00, 0, 0, 0, 4'h0, 8'h00);
      check("coll_data_c", {24'b0, data_io_0}, 32'h66);

      // Write-through bypass in both directions
      step(1, 1, 0, 4'h9, 8'h5C, 1, 0, 1, 4'h9, 8'h00);
      check("bypass_1", {24'b0, data_io_1}, 32'h5C);
      check("bypass_nocoll", {31'b0, collision}, 32'd0);
      step(1, 0, 1, 4'hA, 8'h00, 1, 1, 0, 4'hA, 8'hC5);
      check("bypass_0", {24'b0, data_io_0}, 32'hC5);

      // Distinct-address writes, then simultaneous reads
      step(1, 1, 0, 4'h4, 8'h44, 1, 1, 0, 4'h5, 8'h55);
      check("dual_wr_nocoll", {31'b0, collision}, 32'd0);
      step(1, 0, 1, 4'h5, 8'h00, 1, 0, 1, 4'h4, 8'h00);
      check("dual_rd_0", {24'b0, data_io_0}, 32'h55);
      check("dual_rd_1", {24'b0, data_io_1}, 32'h44);
      step(1, 0, 1, 4'h9, 8'h00, 1, 0, 1, 4'h9, 8'h00);
      check("same_rd_0", {24'b0, data_io_0}, 32'h5C);
      check("same_rd_1", {24'b0, data_io_1}, 32'h5C);
      check("same_rd_nocoll", {31'b0, collision}, 32'd0);

      // Mixed traffic on a narrow address range, checked by the model
      for (int i = 0; i < 80; i++) begin
         logic c0, w0, o0, c1, w1, o1;
         c0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1)); o0 = !w0 && 1'($urandom_range(0, 1));
         c1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1)); o1 = !w1 && 1'($urandom_range(0, 1));
         step(c0, w0, o0, 4'($urandom_range(0, 3)), 8'($urandom),
              c1, w1, o1, 4'($urandom_range(0, 3)), 8'($urandom));
      end

      // Asynchronous reset while read data is on the bus
      step(1, 0, 1, 4'h4, 8'h00, 0, 0, 0, 4'h0, 8'h00);
      check("pre_rst_valid", {31'b0, rd_valid_0}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {31'b0, rd_valid_0}, 32'd0);
      check("arst_busy", {31'b0, init_busy}, 32'd1);
      check("arst_hiz", {24'b0, data_io_0}, {24'b0, PROBE});
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset again at sweep pointer 8; the sweep must restart from 0
      repeat (8) idle();
      check("mid_sweep_busy", {31'b0, init_busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("sweep_rst_busy", {31'b0, init_busy}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (17) idle();
      check("resweep_cycles", busy_cnt, 32'd16);
      step(1, 0, 1, 4'h4, 8'h00, 1, 0, 1, 4'h9, 8'h00);
      check("resweep_data0", {24'b0, data_io_0}, 32'h00);
      check("resweep_data1", {24'b0, data_io_1}, 32'h00);

      // Reset while a collision pulse is high
      collide(8'hAA, 8'hBB);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_coll", {31'b0, collision}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (17) idle();
      check("final_busy", {31'b0, init_busy}, 32'd0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dp_bidir_ram_arb.md
DP_BIDIR_RAM_ARB -- requirements
Module: dp_bidir_ram_arb

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the word width and data bus width.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 Parameter INIT_VAL, default 0, SHALL be the word written to every location during the init sweep.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 cs_0, cs_1  in  1  SHALL be the per-port chip selects.
REQ-007 wr_en_0, wr_en_1  in  1  SHALL select write (1) or read (0) per port.
REQ-008 out_en_0, out_en_1  in  1  SHALL be the per-port output enables.
REQ-009 add_in_0, add_in_1  in  ADDR_W  SHALL be the per-port word addresses.
REQ-010 data_io_0, data_io_1  inout  DATA_W  SHALL be the bidirectional per-port data buses.
REQ-011 rd_valid_0, rd_valid_1  out  1  SHALL be the per-port read-data-valid strobes.
REQ-012 collision  out  1  SHALL be a one-cycle pulse flagging a dropped same-address write.
REQ-013 init_busy  out  1  SHALL be high while the post-reset memory clear runs.

Function
REQ-014 The FSM SHALL have two states, INIT and RUN; reset SHALL force INIT with the sweep pointer at 0.
REQ-015 In INIT, each cycle SHALL write INIT_VAL to mem[pointer] and increment the pointer; after DEPTH-1 is written the FSM SHALL move to RUN, giving exactly DEPTH cycles of init_busy=1.
REQ-016 In INIT, all port requests SHALL be ignored: no writes, no reads, rd_valid low, buses hi-Z.
REQ-017 Port accesses SHALL be accepted only in RUN when cs_x=1.
REQ-018 An accepted write SHALL store data_io_x to mem[add_in_x] at that clock edge.
REQ-019 An accepted read SHALL load mem[add_in_x] into the port read register; rd_valid_x SHALL be high for exactly the next cycle. Read latency SHALL be 1.
REQ-020 The read register SHALL hold its value until the next accepted read on that port.
REQ-021 data_io_x SHALL be driven from the read register only while rd_valid_x=1 and out_en_x=1; otherwise it SHALL be hi-Z.
REQ-022 Same-cycle writes from both ports to the same address SHALL be arbitrated by a 1-bit round-robin pointer (reset value: port 0 wins). Only the winner SHALL be written, and the pointer SHALL toggle after each collision.
REQ-023 On a write collision, collision SHALL pulse high for the following cycle. Writes to different addresses SHALL both complete with no collision.
REQ-024 A read on one port in the same cycle as a write by the other port to the same address SHALL return the newly written data (write-through bypass). This is not a collision.
REQ-025 Simultaneous reads on both ports, including to the same address, SHALL both complete with no collision.
REQ-026 Address arithmetic SHALL be unsigned ADDR_W-bit. The sweep pointer SHALL stop at DEPTH-1 and SHALL NOT wrap.

Reset
REQ-027 rst_n low SHALL immediately set rd_valid_0/1=0, collision=0, init_busy=1, read registers to 0, arbitration pointer to port 0, FSM to INIT, and both buses to hi-Z.
REQ-028 Reset asserted mid-sweep or mid-operation SHALL restart the full sweep after release. Memory contents SHALL be defined only by the sweep, not by the reset itself.

Verification
REQ-029 Release reset, then idle -> init_busy high for 16 cycles then low; port-0 read of any address returns 0x00 with rd_valid_0 pulsing once.
REQ-030 In RUN, port 0 writes 0xA5 to addr 3; next cycle port 1 reads addr 3 with out_en_1=1 -> data_io_1=0xA5 one cycle later, rd_valid_1 high for exactly 1 cycle, bus hi-Z after.
REQ-031 Both ports write addr 7 (0x11 on port 0, 0x22 on port 1) twice in consecutive cycles -> first collision stores 0x11, second stores 0x22; collision pulses each time.
REQ-032 Port 0 writes 0x5C to addr 9 while port 1 reads addr 9 in the same cycle -> port 1 returns 0x5C; collision stays 0.
REQ-033 Port requests issued during INIT -> no memory change and rd_valid low; after INIT all locations read 0x00.
REQ-034 rst_n pulsed low at sweep pointer 8 -> outputs reset asynchronously; after release init_busy is high for 16 cycles from pointer 0.
